tri_bus_arbiter: RTL
====================

// Module: tri_bus_arbiter
// PURPOSE
//  Arbitrates two requesters for the shared wired bus (wand/wor/tri/triand nets) and generates
//  its drive data (a, b) and driver enables (e1, e2). Sits directly upstream of the wand_wor stage.
//  Guarantees single-driver ownership, a programmable turnaround gap between owners, and
//  round-robin fairness with a bounded hold time.
// PARAMETERS
//  WIDTH        1   data width of d1/d2/a/b
//  TURN_CYCLES  1   bus-idle cycles (e1=e2=0) between any two grants; legal range 1..15
//  MAX_HOLD     8   max consecutive grant cycles while the other side requests; legal >= 1
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  req1   in   1      requester 1 wants the bus; level, held while it needs ownership
//  req2   in   1      requester 2 wants the bus
//  d1     in   WIDTH  requester 1 drive data
//  d2     in   WIDTH  requester 2 drive data
//  a      out  WIDTH  registered copy of d1, valid while e1=1, else 0
//  b      out  WIDTH  registered copy of d2, valid while e2=1, else 0
//  e1     out  1      driver-1 enable (registered)
//  e2     out  1      driver-2 enable (registered)
//  gnt1   out  1      requester 1 owns the bus; identical timing to e1
//  gnt2   out  1      requester 2 owns the bus; identical timing to e2
//  busy   out  1      1 in any state except IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, all outputs 0, hold_cnt=0, turn_cnt=0,
//    last=2 so requester 1 wins the first tie. Assertion mid-grant drops e1/e2 immediately,
//    without a clock edge.
//  - States: IDLE, GNT1, GNT2, TURN. All outputs registered from next-state; no comb. paths.
//  - IDLE: only req1 -> GNT1; only req2 -> GNT2; both -> the one != last; none -> stay.
//    Latency: req sampled high at edge N -> gnt/e high after edge N (1 cycle).
//  - GNTk: ek=gntk=1; a (or b) <= dk each cycle; the other enable and data output are 0.
//    hold_cnt increments each GNT cycle, saturating at MAX_HOLD; cleared on entry to GNT.
//  - Leave GNTk -> TURN when reqk sampled 0, or when hold_cnt==MAX_HOLD and other req sampled 1
//    (preemption). The grant is then MAX_HOLD cycles long. With only reqk held, ownership is kept
//    indefinitely. On exit, last<=k.
//  - TURN: e1=e2=gnt1=gnt2=0, a=b=0, busy=1 for exactly TURN_CYCLES cycles (turn_cnt).
//    On the final TURN cycle, arbitrate as IDLE (other side preferred on a tie). If neither
//    requests, go to IDLE. A request dropping during TURN is simply not granted.
//  - Invariant: e1&e2 never 1; every owner change has >= TURN_CYCLES cycles with both enables 0.
//  - Data width: a/b are exact WIDTH copies; no arithmetic. hold_cnt is $clog2(MAX_HOLD+1) bits.
//    turn_cnt is 4 bits.
//  - X on req inputs outside reset is illegal; a bench assertion flags it.
// TESTING
//  1 rst=1 with req1=req2=1 -> e1=e2=gnt1=gnt2=busy=0, a=b=0, both asynchronous to clk.
//  2 req1=1, d1=1 from cycle 0 -> cycle 1: e1=1, gnt1=1, a=1. req1=0 at cycle 5
//    -> cycle 6 TURN (e1=0, busy=1) -> cycle 7 IDLE (busy=0).
//  3 req1=req2=1 right after reset -> gnt1 first. Drop req1 after 3 grants -> 1 TURN cycle
//    -> gnt2 with b=d2.
//  4 req1,req2 held, MAX_HOLD=8, TURN_CYCLES=1 -> gnt1 8 cycles, 1 idle, gnt2 8 cycles,
//    1 idle, repeating.
//  5 TURN_CYCLES=3, switch owners -> exactly 3 cycles with e1=e2=0 between grants.
//    Async rst pulse mid-GNT2 -> e2 drops immediately; after release, a tie goes to requester 1.
//  6 2000 cycles random req/d -> assertion e1&e2==0 always; a==0 whenever e1==0;
//    no requester starved longer than MAX_HOLD+TURN_CYCLES+1 cycles.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
//   Two-requester arbiter for the shared wired bus. Produces the registered
//   drive data (a, b) and driver enables (e1, e2) for the downstream wand/wor
//   stage. Guarantees a single owner at a time, an idle turnaround gap of
//   TURN_CYCLES between owners, and round-robin fairness with a bounded hold.
//
//   state | meaning
//   IDLE  | nobody owns the bus, arbitrate every cycle
//   GNT1  | requester 1 owns the bus (e1/gnt1/a active)
//   GNT2  | requester 2 owns the bus (e2/gnt2/b active)
//   TURN  | both enables off for TURN_CYCLES cycles, arbitrate on the last one
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req1/req2  level requests, held while ownership is needed
//   d1/d2      requester drive data
//   a/b        registered copies of d1/d2 while the matching enable is 1, else 0
//   e1/e2      registered driver enables
//   gnt1/gnt2  ownership flags, same timing as e1/e2
//   busy       1 in every state except IDLE
//
// Parameters: TURN_CYCLES legal 1..15, MAX_HOLD legal >= 1.

module tri_bus_arbiter #(
  parameter int WIDTH       = 1,
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req1,
  input  logic             req2,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             e1,
  output logic             e2,
  output logic             gnt1,
  output logic             gnt2,
  output logic             busy
);

  localparam int              HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX  = HW'(MAX_HOLD);
  localparam logic [3:0]      TURN_LOAD = 4'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, TURN} state_t;

  state_t        state, state_nxt, pick;
  logic [HW-1:0] hold_cnt, hold_nxt, hold_inc;
  logic [3:0]    turn_cnt, turn_nxt;
  // last: 0 = requester 1 owned the bus most recently, 1 = requester 2
  logic          last, last_nxt;

  // Tie goes to whoever did not own the bus last.
  always_comb begin
    if (req1 && req2)
      pick = last ? GNT1 : GNT2;
    else if (req1)
      pick = GNT1;
    else if (req2)
      pick = GNT2;
    else
      pick = IDLE;
  end

  // hold_inc counts grant cycles including the current one, so comparing it
  // to MAX_HOLD yields a grant of exactly MAX_HOLD cycles under preemption.
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HW'(1);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    turn_nxt  = turn_cnt;
    last_nxt  = last;
    case (state)
      IDLE: begin
        state_nxt = pick;
        hold_nxt  = '0;
      end
      GNT1: begin
        hold_nxt = hold_inc;
        if (!req1 || (hold_inc == HOLD_MAX && req2)) begin
          state_nxt = TURN;
          turn_nxt  = TURN_LOAD;
          last_nxt  = 1'b0;
        end
      end
      GNT2: begin
        hold_nxt = hold_inc;
        if (!req2 || (hold_inc == HOLD_MAX && req1)) begin
          state_nxt = TURN;
          turn_nxt  = TURN_LOAD;
          last_nxt  = 1'b1;
        end
      end
      TURN: begin
        if (turn_cnt == 4'd0) begin
          state_nxt = pick;
          hold_nxt  = '0;
        end else begin
          turn_nxt = turn_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so nothing combinational
  // reaches the bus drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      turn_cnt <= '0;
      last     <= 1'b1;
      e1       <= 1'b0;
      e2       <= 1'b0;
      gnt1     <= 1'b0;
      gnt2     <= 1'b0;
      busy     <= 1'b0;
      a        <= '0;
      b        <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      last     <= last_nxt;
      e1       <= (state_nxt == GNT1);
      e2       <= (state_nxt == GNT2);
      gnt1     <= (state_nxt == GNT1);
      gnt2     <= (state_nxt == GNT2);
      busy     <= (state_nxt != IDLE);
      a        <= (state_nxt == GNT1) ? d1 : '0;
      b        <= (state_nxt == GNT2) ? d2 : '0;
    end
  end

endmodule
